// File: rtl/nibble_adder_pkg.sv
// Shared constants and state encoding for the nibble adder tree front end.
package nibble_adder_pkg;

    localparam int unsigned NUM_WORDS     = 128;                       // operands per frame
    localparam int unsigned WORD_W        = 4;                         // operand width
    localparam int unsigned SUM_W         = 11;                        // WORD_W + log2(NUM_WORDS)
    localparam int unsigned CNT_W         = 8;                         // holds the value NUM_WORDS
    localparam int unsigned IDX_W         = $clog2(NUM_WORDS);         // slot index width
    localparam int unsigned SETTLE_CYCLES = 2;                         // frame close to sum capture, >= 1
    localparam int unsigned SETTLE_W      = $clog2(SETTLE_CYCLES + 1); // settle counter width

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } loader_state_t;

endpackage

// File: rtl/nibble_slot_buffer.sv
// NUM_WORDS x WORD_W operand register file.
//   clk     : rising-edge clock
//   clr     : synchronous clear of every slot (wins over write)
//   wr_en   : write wr_data into slot wr_idx
//   wr_idx  : slot index
//   wr_data : word to store
//   rd_bus  : flat view of all slots, slot k at [WORD_W*k +: WORD_W]
module nibble_slot_buffer
    import nibble_adder_pkg::*;
(
    input  logic                        clk,
    input  logic                        clr,
    input  logic                        wr_en,
    input  logic [IDX_W-1:0]            wr_idx,
    input  logic [WORD_W-1:0]           wr_data,
    output logic [NUM_WORDS*WORD_W-1:0] rd_bus
);

    logic [NUM_WORDS-1:0][WORD_W-1:0] slots;

    // Slot storage; clearing is how short frames get zero-padded.
    always_ff @(posedge clk) begin
        if (clr) begin
            slots <= '0;
        end else if (wr_en) begin
            slots[wr_idx] <= wr_data;
        end
    end

    assign rd_bus = slots;

endmodule

// File: rtl/nibble_frame_loader.sv
// Collects a serial stream of nibbles into one operand frame for the external
// adder tree, waits for the tree to settle, and hands the sum downstream.
//   clk, rst                    : clock, synchronous active-high reset
//   in_valid/in_ready/in_data   : input word handshake
//   in_last                     : closes a short frame
//   tree_operands / tree_sum    : parallel bus to the tree and its result
//   out_valid/out_ready         : result handshake
//   out_sum / out_count         : captured sum and number of words in the frame
//   busy                        : high while settling or holding a result
module nibble_frame_loader
    import nibble_adder_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WORD_W-1:0]           in_data,
    input  logic                        in_last,
    output logic [NUM_WORDS*WORD_W-1:0] tree_operands,
    input  logic [SUM_W-1:0]            tree_sum,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [SUM_W-1:0]            out_sum,
    output logic [CNT_W-1:0]            out_count,
    output logic                        busy
);

    loader_state_t       state, state_next;
    logic [CNT_W-1:0]    count, count_next;
    logic [SETTLE_W-1:0] settle_cnt, settle_next;
    logic                accept_c;
    logic                capture_c;
    logic                release_c;
    logic                in_ready_next;
    logic                out_valid_next;
    logic                busy_next;

    // Operand storage; cleared by reset or once the result is taken.
    nibble_slot_buffer u_slots (
        .clk     (clk),
        .clr     (rst | release_c),
        .wr_en   (accept_c),
        .wr_idx  (count[IDX_W-1:0]),
        .wr_data (in_data),
        .rd_bus  (tree_operands)
    );

    // Next-state, counters and next values of the registered outputs.
    always_comb begin
        state_next  = state;
        count_next  = count;
        settle_next = settle_cnt;
        accept_c    = 1'b0;
        capture_c   = 1'b0;
        release_c   = 1'b0;

        case (state)
            FILL: begin
                accept_c = in_valid & in_ready;
                if (accept_c) begin
                    count_next = CNT_W'(count + CNT_W'(1));
                    if (in_last || (count == CNT_W'(NUM_WORDS - 1))) begin
                        state_next  = SETTLE;
                        settle_next = SETTLE_W'(SETTLE_CYCLES - 1);
                    end
                end
            end
            SETTLE: begin
                if (settle_cnt == '0) begin
                    capture_c  = 1'b1;
                    state_next = HOLD;
                end else begin
                    settle_next = SETTLE_W'(settle_cnt - SETTLE_W'(1));
                end
            end
            HOLD: begin
                if (out_ready) begin
                    release_c  = 1'b1;
                    count_next = '0;
                    state_next = FILL;
                end
            end
            default: begin
                state_next = FILL;
            end
        endcase

        in_ready_next  = (state_next == FILL);
        out_valid_next = (state_next == HOLD);
        busy_next      = (state_next != FILL);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FILL;
            count      <= '0;
            settle_cnt <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            out_sum    <= '0;
            out_count  <= '0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            settle_cnt <= settle_next;
            in_ready   <= in_ready_next;
            out_valid  <= out_valid_next;
            busy       <= busy_next;
            if (capture_c) begin
                out_sum   <= tree_sum;
                out_count <= count;
            end
        end
    end

    // Structural invariants.
    a_count_max : assert property (@(posedge clk) disable iff (rst)
        count <= CNT_W'(NUM_WORDS));
    a_ops_stable : assert property (@(posedge clk) disable iff (rst)
        (state != FILL && $past(state) != FILL) |-> $stable(tree_operands));
    a_ready_valid : assert property (@(posedge clk) disable iff (rst)
        !(in_ready && out_valid));

endmodule

// File: tb/tb_nibble_frame_loader.sv
// Directed bench for nibble_frame_loader with a behavioural adder tree and a
// result scoreboard.
module tb_nibble_frame_loader;
    import nibble_adder_pkg::*;

    typedef struct packed {
        logic [SUM_W-1:0] sum;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        in_valid;
    logic                        in_ready;
    logic [WORD_W-1:0]           in_data;
    logic                        in_last;
    logic [NUM_WORDS*WORD_W-1:0] tree_operands;
    logic [SUM_W-1:0]            tree_sum;
    logic                        out_valid;
    logic                        out_ready;
    logic [SUM_W-1:0]            out_sum;
    logic [CNT_W-1:0]            out_count;
    logic                        busy;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    nibble_frame_loader dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_last       (in_last),
        .tree_operands (tree_operands),
        .tree_sum      (tree_sum),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_sum       (out_sum),
        .out_count     (out_count),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the adder tree.
    function automatic logic [SUM_W-1:0] tree_add(input logic [NUM_WORDS*WORD_W-1:0] ops);
        logic [SUM_W-1:0] s;
        s = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            s = SUM_W'(s + SUM_W'(ops[k*WORD_W +: WORD_W]));
        end
        return s;
    endfunction

    always_comb tree_sum = tree_add(tree_operands);

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, act, exp);
        end
    endtask

    // Drive one word at a negedge and stay until it is consumed (bounded).
    task automatic send_word(input logic [WORD_W-1:0] d, input logic last);
        int w;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        w = 0;
        while (!in_ready && w < 60) begin
            @(negedge clk);
            w++;
        end
        if (w >= 60) check("send_timeout", 32'(w), 32'(0));
        @(negedge clk);
    endtask

    task automatic wait_valid(input int budget, output int waited);
        waited = 0;
        while (!out_valid && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= budget) check("valid_timeout", 32'(waited), 32'(0));
    endtask

    // Scoreboard: compare every accepted result against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            exp_t e;
            checks++;
            assert (sb_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_result observed_sum=%0d expected=none", out_sum);
            end
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("result_sum", 32'(out_sum), 32'(e.sum));
                check("result_count", 32'(out_count), 32'(e.cnt));
            end
        end
    end

    initial begin
        int lat;
        exp_t e;
        logic [NUM_WORDS*WORD_W-1:0] exp_ops;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_sum", 32'(out_sum), 32'(0));
        check("rst_out_count", 32'(out_count), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_ops_zero", 32'(tree_operands == '0), 32'(1));

        // Full frame of 4'hF, in_last on word 128 as well (single close).
        // The cycle carrying the last word is cycle 0; out_valid is due in cycle 3.
        e.sum = SUM_W'(1920); e.cnt = CNT_W'(128); sb_q.push_back(e);
        for (int i = 0; i < NUM_WORDS; i++) send_word(4'hF, (i == NUM_WORDS - 1));
        in_valid = 1'b0; in_last = 1'b0;
        check("full_settle_busy", 32'(busy), 32'(1));
        check("full_settle_ready", 32'(in_ready), 32'(0));
        wait_valid(10, lat);
        check("full_latency", 32'(lat + 1), 32'(SETTLE_CYCLES + 1));
        @(negedge clk);
        check("full_ready_again", 32'(in_ready), 32'(1));
        check("full_valid_clear", 32'(out_valid), 32'(0));
        check("full_busy_clear", 32'(busy), 32'(0));

        // Short frame 5,6,7 -> 18 / 3, slots 3..127 stay zero.
        e.sum = SUM_W'(18); e.cnt = CNT_W'(3); sb_q.push_back(e);
        send_word(4'd5, 1'b0);
        send_word(4'd6, 1'b0);
        send_word(4'd7, 1'b1);
        in_valid = 1'b0; in_last = 1'b0;
        exp_ops = '0;
        exp_ops[3:0] = 4'd5; exp_ops[7:4] = 4'd6; exp_ops[11:8] = 4'd7;
        checks++;
        assert (tree_operands === exp_ops) else begin
            failures++;
            $error("FAIL short_ops observed_sum=%0d expected_sum=18", tree_add(tree_operands));
        end
        wait_valid(10, lat);
        @(negedge clk);

        // Backpressure: full frame of 1s closed by count, held 20 cycles.
        out_ready = 1'b0;
        e.sum = SUM_W'(128); e.cnt = CNT_W'(128); sb_q.push_back(e);
        for (int i = 0; i < NUM_WORDS; i++) send_word(4'h1, 1'b0);
        in_valid = 1'b1; in_data = 4'd7; in_last = 1'b1;   // offered while busy
        wait_valid(10, lat);
        for (int i = 0; i < 20; i++) begin
            check("bp_valid_held", 32'(out_valid), 32'(1));
            check("bp_ready_low", 32'(in_ready), 32'(0));
            @(negedge clk);
        end
        check("bp_sum_held", 32'(out_sum), 32'(128));
        check("bp_count_held", 32'(out_count), 32'(128));
        e.sum = SUM_W'(7); e.cnt = CNT_W'(1); sb_q.push_back(e);
        out_ready = 1'b1;
        send_word(4'd7, 1'b1);
        in_valid = 1'b0; in_last = 1'b0;
        wait_valid(10, lat);
        @(negedge clk);

        // Back-to-back frames; B is offered while A is still in flight.
        e.sum = SUM_W'(5); e.cnt = CNT_W'(2); sb_q.push_back(e);
        e.sum = SUM_W'(1); e.cnt = CNT_W'(1); sb_q.push_back(e);
        send_word(4'd2, 1'b0);
        send_word(4'd3, 1'b1);
        send_word(4'd1, 1'b1);
        in_valid = 1'b0; in_last = 1'b0;
        exp_ops = '0;
        exp_ops[3:0] = 4'd1;
        checks++;
        assert (tree_operands === exp_ops) else begin
            failures++;
            $error("FAIL b2b_cleared observed_sum=%0d expected_sum=1", tree_add(tree_operands));
        end
        wait_valid(10, lat);
        @(negedge clk);

        // Reset mid-fill discards the partial frame.
        for (int i = 0; i < 60; i++) send_word(4'h9, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midfill_ready", 32'(in_ready), 32'(1));
        check("midfill_ops_zero", 32'(tree_operands == '0), 32'(1));
        e.sum = SUM_W'(4); e.cnt = CNT_W'(1); sb_q.push_back(e);
        send_word(4'd4, 1'b1);
        in_valid = 1'b0; in_last = 1'b0;
        wait_valid(10, lat);
        @(negedge clk);

        // Reset during HOLD discards the pending result.
        out_ready = 1'b0;
        send_word(4'd3, 1'b1);
        in_valid = 1'b0; in_last = 1'b0;
        wait_valid(10, lat);
        check("hold_valid", 32'(out_valid), 32'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("hold_rst_valid", 32'(out_valid), 32'(0));
        check("hold_rst_sum", 32'(out_sum), 32'(0));
        check("hold_rst_count", 32'(out_count), 32'(0));
        check("hold_rst_ready", 32'(in_ready), 32'(1));
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/nibble_frame_loader.md
Name: nibble_frame_loader

Overview:
- Upstream stage for the 128-operand nibble adder tree.
- Accepts a serial stream of 4-bit words over a valid/ready handshake and assembles one frame of up to 128 words into a parallel operand bus that drives the combinational tree.
- Waits a fixed settle time, captures the tree's 11-bit sum, and presents it downstream with a valid/ready handshake.

Parameters:
- NUM_WORDS, 128, operands per frame (number of tree inputs)
- WORD_W, 4, operand width
- SUM_W, 11, tree result width; equals WORD_W + log2(NUM_WORDS)
- CNT_W, 8, word-counter width; must hold the value NUM_WORDS
- SETTLE_CYCLES, 2, clocks between frame close and sum capture; minimum 1

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  loader can accept a word
- in_data  in  WORD_W  input word
- in_last  in  1  marks final word of a short frame
- tree_operands  out  NUM_WORDS*WORD_W  flat operand bus; word k at bits [WORD_W*k+WORD_W-1 : WORD_W*k]; k=0 feeds the tree's first input
- tree_sum  in  SUM_W  combinational sum returned by the adder tree
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_sum  out  SUM_W  captured frame sum
- out_count  out  CNT_W  number of words accepted in the frame (1..NUM_WORDS)
- busy  out  1  high in SETTLE and HOLD

Behaviour:
- Reset (synchronous to clk, active-high; the only reset behaviour) forces:
  - state = FILL
  - operand buffer all zero, word count 0
  - in_ready = 1
  - out_valid = 0, out_sum = 0, out_count = 0, busy = 0
- FILL state:
  - in_ready = 1.
  - On in_valid & in_ready, in_data is written to slot[count] and count increments.
  - The frame closes when the accepted word has in_last = 1, or when it is word NUM_WORDS (count reaches NUM_WORDS). Either condition moves the state to SETTLE on the next edge.
  - Unwritten slots stay zero, so a short frame sums correctly.
- SETTLE state:
  - in_ready = 0; tree_operands held constant.
  - Settle counter loads SETTLE_CYCLES-1 on entry and decrements each clock.
  - At 0, tree_sum is registered into out_sum, count into out_count, and out_valid is set. Next state: HOLD.
- HOLD state:
  - out_valid = 1; in_ready = 0; out_sum and out_count stable.
  - On out_valid & out_ready: out_valid clears, operand buffer and count clear, next state FILL.
  - in_ready rises the cycle after the handshake.
- Latency:
  - Last input handshake to out_valid = SETTLE_CYCLES + 1 clocks.
  - In HOLD, out_valid stays high indefinitely until out_ready.
- Boundary conditions:
  - in_last on the word that is also word NUM_WORDS: a single frame close, out_count = NUM_WORDS.
  - No empty frames: a frame always contains at least 1 word.
  - in_valid in SETTLE/HOLD is ignored and the word is not consumed.
  - rst in any state aborts the frame; the partial frame and any pending result are discarded.
- Arithmetic:
  - No overflow possible; the maximum sum is NUM_WORDS*(2^WORD_W-1) = 1920, which is below 2^SUM_W.
  - The loader performs no addition itself.
- Assertions:
  - count never exceeds NUM_WORDS.
  - tree_operands stable throughout SETTLE and HOLD.
  - in_ready & out_valid never both high.

Decomposition:
- Shared package nibble_adder_pkg holds:
  - constants NUM_WORDS, WORD_W, SUM_W, CNT_W
  - enum loader_state_t {FILL, SETTLE, HOLD}
- Sub-module nibble_slot_buffer: NUM_WORDS x WORD_W register file with write-enable, index, synchronous clear, and flat read-out bus.
- FSM and counters stay in the top module.
- The adder tree is instantiated by the parent, not inside this block.

Test Plan:
- Full frame, 128 words of 4'hF, no backpressure, out_ready=1 -> out_valid 3 clocks after the last word; out_sum=1920, out_count=128; in_ready high again the next cycle.
- Short frame 5, 6, 7 with in_last on the 7 -> out_sum=18, out_count=3; slots 3..127 read 0 on tree_operands.
- Backpressure: full frame of 4'h1 with out_ready=0 for 20 cycles -> out_valid and out_sum=128 held; in_ready=0 throughout; in_valid words offered during HOLD are not consumed.
- Back-to-back frames: frame A (2,3 last), then frame B (1 last) offered immediately -> results 5/count 2, then 1/count 1; buffer cleared between frames, so B's slot 1 is 0.
- Reset mid-fill: 60 words of 4'h9, then rst for 1 cycle, then 1 word 4'h4 with in_last -> out_sum=4, out_count=1; no result emitted for the aborted frame.
- Reset during HOLD: rst while out_valid=1 -> out_valid=0, out_sum=0, in_ready=1 on the following cycle.
